// File: rtl/cv32e40p_sleep_gate_ctrl_if.sv
// Sleep/wake handshake bundle between the core-side logic
// and the clock-gate enable controller.
interface cv32e40p_sleep_gate_ctrl_if;
  logic        core_sleep_i;
  logic [31:0] irq_i;
  logic [31:0] irq_mask_i;
  logic        debug_req_i;
  logic        force_on_i;
  logic        clr_cnt_i;
  logic        clk_en_o;
  logic        pwr_en_o;
  logic        gated_o;
  logic        wake_evt_o;
  logic [31:0] sleep_cnt_o;

  modport master (
    output core_sleep_i,
    output irq_i,
    output irq_mask_i,
    output debug_req_i,
    output force_on_i,
    output clr_cnt_i,
    input  clk_en_o,
    input  pwr_en_o,
    input  gated_o,
    input  wake_evt_o,
    input  sleep_cnt_o
  );

  modport slave (
    input  core_sleep_i,
    input  irq_i,
    input  irq_mask_i,
    input  debug_req_i,
    input  force_on_i,
    input  clr_cnt_i,
    output clk_en_o,
    output pwr_en_o,
    output gated_o,
    output wake_evt_o,
    output sleep_cnt_o
  );
endinterface

// File: rtl/cv32e40p_sleep_gate_ctrl.sv
// Clock-gate enable controller: idle hysteresis before gating
// and a staged power-then-functional clock wake-up.
module cv32e40p_sleep_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input logic clk_i,
  input logic rst_i,
  cv32e40p_sleep_gate_ctrl_if.slave bus
);

  localparam int unsigned MAX_CYC =
    (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES
                                : WAKE_CYCLES;
  localparam int unsigned CW = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] IDLE_LAST =
    CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] WAKE_LAST =
    CW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    IDLE_WAIT = 2'd1,
    GATED     = 2'd2,
    WAKE      = 2'd3
  } state_e;

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          evt_d;
  logic          wake_cond;
  logic          leave_idle;

  logic        clk_en_q;
  logic        pwr_en_q;
  logic        gated_q;
  logic        evt_q;
  logic [31:0] sleep_cnt_q;

  assign wake_cond = |(bus.irq_i & bus.irq_mask_i)
                   | bus.debug_req_i
                   | bus.force_on_i;

  assign leave_idle = ~bus.core_sleep_i | wake_cond;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evt_d   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.core_sleep_i && !wake_cond) begin
          state_d = IDLE_WAIT;
          cnt_d   = '0;
        end
      end
      IDLE_WAIT: begin
        if (leave_idle) begin
          state_d = RUN;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = GATED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GATED: begin
        if (leave_idle) begin
          state_d = WAKE;
          cnt_d   = '0;
        end
      end
      WAKE: begin
        // inputs ignored: a started wake-up always completes
        if (cnt_q == WAKE_LAST) begin
          state_d = RUN;
          evt_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // enables decoded from next state so they switch with it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      clk_en_q    <= 1'b1;
      pwr_en_q    <= 1'b1;
      gated_q     <= 1'b0;
      evt_q       <= 1'b0;
      sleep_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_en_q <= (state_d == RUN)
                | (state_d == IDLE_WAIT);
      pwr_en_q <= (state_d != GATED);
      gated_q  <= (state_d == GATED);
      evt_q    <= evt_d;
      if (bus.clr_cnt_i) begin
        sleep_cnt_q <= '0;
      end else if (state_q == GATED &&
                   sleep_cnt_q != 32'hFFFF_FFFF) begin
        sleep_cnt_q <= sleep_cnt_q + 32'd1;
      end
    end
  end

  assign bus.clk_en_o    = clk_en_q;
  assign bus.pwr_en_o    = pwr_en_q;
  assign bus.gated_o     = gated_q;
  assign bus.wake_evt_o  = evt_q;
  assign bus.sleep_cnt_o = sleep_cnt_q;

endmodule
